dvv_bus_arb: RTL

//  Round-robin arbiter/sequencer sharing one simple req/ack slave bus between N_REQ masters.

---
 rtl/dvv_bus_arb.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dvv_bus_arb.sv
// dvv_bus_arb - round-robin arbiter sharing one req/ack slave bus between N_REQ masters.
//
// The winning master's command (we/addr/wdata) is captured in IDLE and one transaction
// is run on the slave port. Completion (ack + rdata) is returned to that master for a
// single cycle, then the arbiter goes back to IDLE.
//
// Optional feature macro: DVV_ARB_TIMEOUT_EN
//   defined   : a slave that has not acked after TMO_CYC cycles of m_req completes the
//               transaction with err=1 and rdata=0.
//   undefined : BUSY waits for m_ack indefinitely and err is tied low.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req/lock/we       per-master request, keep-priority hint, write enable
//   addr/wdata        per-master command, master i at [i*AW +: AW] / [i*DW +: DW]
//   gnt               one-hot grant, held from BUSY through RESP
//   ack/rdata/err     one-cycle completion to the granted master
//   m_req/m_we/m_addr/m_wdata   slave command, registered
//   m_ack/m_rdata     slave completion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate among req each cycle
// BUSY  | command captured, m_req high, waiting for m_ack (or timeout)
// RESP  | one cycle: ack pulse to the winner, gnt still held

module dvv_bus_arb #(
  parameter int N_REQ   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  logic [N_REQ-1:0]      we,
  input  logic [N_REQ*AW-1:0]   addr,
  input  logic [N_REQ*DW-1:0]   wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      ack,
  output logic [DW-1:0]         rdata,
  output logic                  err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [AW-1:0]         m_addr,
  output logic [DW-1:0]         m_wdata,
  input  logic                  m_ack,
  input  logic [DW-1:0]         m_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;

`ifdef DVV_ARB_TIMEOUT_EN
  localparam int              CW     = $clog2(TMO_CYC);
  localparam logic [CW-1:0]   CNT_TC = CW'(TMO_CYC - 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Round-robin search: first requesting master after ptr, wrapping modulo N_REQ.
  logic [PW-1:0]     arb_idx;
  logic              arb_hit;
  int unsigned       cand;

  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!arb_hit && req[cand[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[PW-1:0];
      end
    end
  end

  // With lock held the pointer parks just before the winner so it wins again.
  logic [PW-1:0]     ptr_keep;
  assign ptr_keep = (win_q == '0) ? PW'(N_REQ - 1) : (win_q - PW'(1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
`ifdef DVV_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        rdata_d = '0;
        if (arb_hit) begin
          win_d          = arb_idx;
          gnt_d[arb_idx] = 1'b1;
          m_req_d        = 1'b1;
          m_we_d         = we[arb_idx];
          m_addr_d       = addr[int'(arb_idx)*AW +: AW];
          m_wdata_d      = wdata[int'(arb_idx)*DW +: DW];
          state_d        = ST_BUSY;
`ifdef DVV_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (m_ack) begin
          m_req_d      = 1'b0;
          rdata_d      = m_rdata;
          ack_d[win_q] = 1'b1;
          ptr_d        = lock[win_q] ? ptr_keep : win_q;
          state_d      = ST_RESP;
        end
`ifdef DVV_ARB_TIMEOUT_EN
        // m_ack in the terminal-count cycle takes the branch above.
        else if (cnt_q == CNT_TC) begin
          m_req_d      = 1'b0;
          rdata_d      = '0;
          ack_d[win_q] = 1'b1;
          err_d        = 1'b1;
          ptr_d        = win_q;
          state_d      = ST_RESP;
        end else begin
          cnt_d        = cnt_q + CW'(1);
        end
`endif
      end

      ST_RESP: begin
        gnt_d   = '0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        rdata_d = '0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PW'(N_REQ - 1);
      win_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
`ifdef DVV_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
`ifdef DVV_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
`ifdef DVV_ARB_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
